// File: rtl/ksa_shuffle_if.sv
// Working-memory port of the RC4 key-scheduling block: address/write bus out, read data back.
// master = shuffle engine, slave = memory_handler side.
interface ksa_shuffle_if;
    logic [7:0] address_shuffle;
    logic [7:0] data_shuffle;
    logic       wren_shuffle;
    logic [1:0] mem_sel_shuffle;
    logic [7:0] output_data_shuffle;

    modport master (
        output address_shuffle,
        output data_shuffle,
        output wren_shuffle,
        output mem_sel_shuffle,
        input  output_data_shuffle
    );

    modport slave (
        input  address_shuffle,
        input  data_shuffle,
        input  wren_shuffle,
        input  mem_sel_shuffle,
        output output_data_shuffle
    );
endinterface

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap loop over a 256-byte working memory; KSA_SHUFFLE_DBG_EN adds dbg_i/dbg_j/dbg_state.
// 8 cycles per i (two 2-edge reads, two 1-cycle writes), DONE 2048 cycles after leaving IDLE; no backpressure, memory assumed always ready.
module ksa_shuffle (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_shuffle,
    input  logic [23:0]          secret_key,
    output logic                 done_shuffle,
    ksa_shuffle_if.master        mem_bus
`ifdef KSA_SHUFFLE_DBG_EN
    ,
    output logic [7:0]           dbg_i,
    output logic [7:0]           dbg_j,
    output logic [3:0]           dbg_state
`endif
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_SI    = 4'd1,
        WAIT_SI  = 4'd2,
        LATCH_SI = 4'd3,
        RD_SJ    = 4'd4,
        WAIT_SJ  = 4'd5,
        LATCH_SJ = 4'd6,
        WR_SI    = 4'd7,
        WR_SJ    = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [1:0] k_q, k_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] key_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 2'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    // Key byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = secret_key[7:0];
        case (k_q)
            2'd0:    key_byte = secret_key[23:16];
            2'd1:    key_byte = secret_key[15:8];
            default: key_byte = secret_key[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        case (state_q)
            IDLE: begin
                if (start_shuffle) begin
                    state_d = RD_SI;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 2'd0;
                end
            end
            RD_SI:   state_d = WAIT_SI;
            WAIT_SI: state_d = LATCH_SI;
            LATCH_SI: begin
                si_d    = mem_bus.output_data_shuffle;
                j_d     = j_q + mem_bus.output_data_shuffle + key_byte;
                state_d = RD_SJ;
            end
            RD_SJ:   state_d = WAIT_SJ;
            WAIT_SJ: state_d = LATCH_SJ;
            LATCH_SJ: begin
                sj_d    = mem_bus.output_data_shuffle;
                state_d = WR_SI;
            end
            WR_SI:   state_d = WR_SJ;
            WR_SJ: begin
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                    state_d = RD_SI;
                end
            end
            DONE: begin
                if (!start_shuffle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address is held through wait/latch so the two-edge read pipeline sees a stable index.
    always_comb begin
        mem_bus.address_shuffle = 8'd0;
        mem_bus.data_shuffle    = 8'd0;
        mem_bus.wren_shuffle    = 1'b0;
        mem_bus.mem_sel_shuffle = 2'b00;
        done_shuffle            = 1'b0;
        case (state_q)
            RD_SI, WAIT_SI, LATCH_SI: begin
                mem_bus.address_shuffle = i_q;
                mem_bus.mem_sel_shuffle = 2'b01;
            end
            RD_SJ, WAIT_SJ, LATCH_SJ: begin
                mem_bus.address_shuffle = j_q;
                mem_bus.mem_sel_shuffle = 2'b01;
            end
            WR_SI: begin
                mem_bus.address_shuffle = i_q;
                mem_bus.data_shuffle    = sj_q;
                mem_bus.wren_shuffle    = 1'b1;
                mem_bus.mem_sel_shuffle = 2'b01;
            end
            WR_SJ: begin
                mem_bus.address_shuffle = j_q;
                mem_bus.data_shuffle    = si_q;
                mem_bus.wren_shuffle    = 1'b1;
                mem_bus.mem_sel_shuffle = 2'b01;
            end
            DONE:    done_shuffle = 1'b1;
            default: done_shuffle = 1'b0;
        endcase
    end

`ifdef KSA_SHUFFLE_DBG_EN
    assign dbg_i     = i_q;
    assign dbg_j     = j_q;
    assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: 2-edge-latency memory model, RC4 KSA reference model feeding an expected-write queue.
module tb_ksa_shuffle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_shuffle = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic        done_shuffle;

    ksa_shuffle_if mif();

    ksa_shuffle dut (
        .clk           (clk),
        .reset         (reset),
        .start_shuffle (start_shuffle),
        .secret_key    (secret_key),
        .done_shuffle  (done_shuffle),
        .mem_bus       (mif.master)
    );

    always #5 clk = ~clk;

    logic [7:0] mem      [256];
    logic [7:0] init_img [256];
    logic [7:0] sm       [256];
    logic [7:0] addr_r = 8'd0;
    logic [7:0] rdata  = 8'd0;
    bit         load_mem = 1'b0;

    assign mif.output_data_shuffle = rdata;

    always @(posedge clk) begin
        addr_r <= mif.address_shuffle;
        rdata  <= mem[addr_r];
        if (load_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_img[a];
        end else if (mif.wren_shuffle && mif.mem_sel_shuffle == 2'b01) begin
            mem[mif.address_shuffle] <= mif.data_shuffle;
        end
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [23:0] key;
        int          mode;       // 0 identity, 1 identity with S[0]/S[255] swapped, 2 keep memory, 3 reversed
        int          drop_i;     // iteration at which start is dropped, -1 = held through DONE
        bit          chk_prefix;
        int          wa0;        // expected first two write addresses, -1 = not checked
        int          wa1;
    } vec_t;

    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    int   wa_log [2];
    vec_t vecs [0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock, sample #1 later, and score any write pulse against the model queue.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (mif.wren_shuffle) begin
            if (wr_cnt < 2) wa_log[wr_cnt] = int'(mif.address_shuffle);
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL write_extra: got addr 0x%0h data 0x%0h, want no write",
                         mif.address_shuffle, mif.data_shuffle);
            end else begin
                e = exp_q.pop_front();
                chk("write", {16'd0, mif.address_shuffle, mif.data_shuffle}, {16'd0, e});
            end
        end
    endtask

    // Software RC4 KSA over the current memory image; fills exp_q and leaves the final S in sm.
    task automatic prep(input logic [23:0] key);
        int         j;
        logic [7:0] t;
        logic [7:0] kb;
        exp_q.delete();
        for (int a = 0; a < 256; a++) sm[a] = mem[a];
        j = 0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = (j + int'(sm[i]) + int'(kb)) % 256;
            exp_q.push_back({i[7:0], sm[j]});
            exp_q.push_back({j[7:0], sm[i]});
            t     = sm[i];
            sm[i] = sm[j];
            sm[j] = t;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int done_at;
        int bad;
        if (v.mode != 2) begin
            for (int a = 0; a < 256; a++) begin
                init_img[a] = (v.mode == 3) ? ~a[7:0] : a[7:0];
                if (v.mode == 1 && a == 0)   init_img[a] = 8'hFF;
                if (v.mode == 1 && a == 255) init_img[a] = 8'h00;
            end
            load_mem = 1'b1;
            step();
            load_mem = 1'b0;
        end
        prep(v.key);
        secret_key    = v.key;
        wr_cnt        = 0;
        start_shuffle = 1'b1;
        step();
        chk({tag, "_mem_sel_busy"}, {30'd0, mif.mem_sel_shuffle}, 32'd1);
        done_at = -1;
        for (int c = 1; c <= 2100; c++) begin
            step();
            if (v.chk_prefix && c == 24)
                chk({tag, "_s0_s3_after_i2"}, {mem[0], mem[1], mem[2], mem[3]}, 32'h0001_0302);
            if (v.drop_i >= 0 && c == 8 * v.drop_i) start_shuffle = 1'b0;
            if (done_shuffle) begin
                done_at = c;
                break;
            end
        end
        chk({tag, "_done_cycle"}, done_at, 2048);
        chk({tag, "_write_pulses"}, wr_cnt, 512);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== sm[a]) bad++;
        chk({tag, "_final_s_bad_entries"}, bad, 0);
        if (v.wa0 >= 0) begin
            chk({tag, "_first_wr_addr"}, wa_log[0], v.wa0);
            chk({tag, "_second_wr_addr"}, wa_log[1], v.wa1);
        end
        if (v.drop_i < 0) begin
            step();
            step();
            chk({tag, "_done_held"}, {31'd0, done_shuffle}, 32'd1);
            start_shuffle = 1'b0;
            step();
        end else begin
            step();
        end
        chk({tag, "_done_fall"}, {31'd0, done_shuffle}, 32'd0);
        chk({tag, "_idle_bus"}, {13'd0, mif.wren_shuffle, mif.mem_sel_shuffle,
                                 mif.address_shuffle, mif.data_shuffle}, 32'd0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{key: 24'h000000, mode: 0, drop_i: -1, chk_prefix: 1'b1, wa0: 0, wa1: 0};
        vecs[1] = '{key: 24'h000249, mode: 0, drop_i: -1, chk_prefix: 1'b0, wa0: 0, wa1: 0};
        vecs[2] = '{key: 24'hFFFFFF, mode: 1, drop_i: -1, chk_prefix: 1'b0, wa0: 0, wa1: 8'hFE};
        vecs[3] = '{key: 24'h0A1B2C, mode: 3, drop_i: 10, chk_prefix: 1'b0, wa0: 0, wa1: 9};

        reset = 1'b1;
        step();
        step();
        chk("reset_wren", {31'd0, mif.wren_shuffle}, 32'd0);
        chk("reset_addr", {24'd0, mif.address_shuffle}, 32'd0);
        chk("reset_data", {24'd0, mif.data_shuffle}, 32'd0);
        chk("reset_mem_sel", {30'd0, mif.mem_sel_shuffle}, 32'd0);
        chk("reset_done", {31'd0, done_shuffle}, 32'd0);
        reset = 1'b0;
        step();

        for (int n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("v%0d", n));

        // Abort in WR_SI of i=100, then restart from the partially shuffled memory.
        prep(24'h13579B);
        secret_key    = 24'h13579B;
        wr_cnt        = 0;
        start_shuffle = 1'b1;
        step();
        for (int c = 1; c <= 806; c++) step();
        chk("wr_si_i100_wren", {31'd0, mif.wren_shuffle}, 32'd1);
        chk("wr_si_i100_addr", {24'd0, mif.address_shuffle}, 32'd100);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_wren", {31'd0, mif.wren_shuffle}, 32'd0);
        chk("arst_done", {31'd0, done_shuffle}, 32'd0);
        chk("arst_addr_sel", {22'd0, mif.mem_sel_shuffle, mif.address_shuffle}, 32'd0);
        start_shuffle = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) step();
        chk("idle_after_reset_writes", wr_cnt, 0);
        chk("idle_after_reset_done", {31'd0, done_shuffle}, 32'd0);
        rv = '{key: 24'h13579B, mode: 2, drop_i: -1, chk_prefix: 1'b0, wa0: -1, wa1: -1};
        run_vec(rv, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
